// File: rtl/cache_victim_writeback.sv
// Victim writeback queue: captures dirty evicted lines, drains them to the bus
// as AHBW-wide beats, and flags refill addresses that collide with queued lines.
module cache_victim_writeback #(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned LINELEN = 256,
    parameter int unsigned AHBW    = 64,
    parameter int unsigned PA_BITS = 32,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         EvictValid,
    output logic                         EvictReady,
    input  logic [NUMWAYS-1:0]           VictimWay,
    input  logic [NUMWAYS-1:0]           WayDirty,
    input  logic [NUMWAYS*LINELEN-1:0]   WayLines,
    input  logic [NUMWAYS*PA_BITS-1:0]   WayLineAdr,
    output logic                         BusValid,
    input  logic                         BusReady,
    output logic [PA_BITS-1:0]           BusAdr,
    output logic [AHBW-1:0]              BusData,
    output logic                         BusLast,
    input  logic [PA_BITS-1:0]           LookupAdr,
    output logic                         LookupHit,
    output logic                         Empty
);

    localparam int unsigned BEATS  = LINELEN / AHBW;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(LINELEN / 8);
    localparam int unsigned STEP   = AHBW / 8;

    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [DEPTH-1:0]   vld_q, vld_d;

    logic [LINELEN-1:0] data_q [DEPTH];
    logic [PA_BITS-1:0] adr_q  [DEPTH];

    logic [LINELEN-1:0] sel_line;
    logic [PA_BITS-1:0] sel_adr;
    logic               sel_dirty;
    logic               push;
    logic               beat_acc;
    logic               line_done;
    logic [LINELEN-1:0] head_line;
    logic               lookup_unused;

    // Victim selection: AND-OR mux across ways keyed by the one-hot VictimWay
    always_comb begin
        sel_line  = '0;
        sel_adr   = '0;
        sel_dirty = 1'b0;
        for (int unsigned w = 0; w < NUMWAYS; w++) begin
            sel_line  |= WayLines[w*LINELEN +: LINELEN] & {LINELEN{VictimWay[w]}};
            sel_adr   |= WayLineAdr[w*PA_BITS +: PA_BITS] & {PA_BITS{VictimWay[w]}};
            sel_dirty |= WayDirty[w] & VictimWay[w];
        end
    end

    // Status and handshakes derived from registered occupancy only
    assign Empty      = (cnt_q == '0);
    assign EvictReady = (cnt_q != CNT_W'(DEPTH));
    assign BusValid   = ~Empty;
    assign BusLast    = BusValid & (beat_q == BEAT_W'(BEATS - 1));
    assign push       = EvictValid & EvictReady & sel_dirty;
    assign beat_acc   = BusValid & BusReady;
    assign line_done  = beat_acc & BusLast;

    // Next-state for pointers, occupancy, beat counter and entry valid bits
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        vld_d  = vld_q;
        if (beat_acc) begin
            beat_d = line_done ? '0 : beat_q + BEAT_W'(1);
        end
        if (line_done) begin
            rd_d        = rd_q + PTR_W'(1);
            vld_d[rd_q] = 1'b0;
        end
        // wr and rd only alias when empty (no pop) or full (no push)
        if (push) begin
            wr_d        = wr_q + PTR_W'(1);
            vld_d[wr_q] = 1'b1;
        end
        if (push && !line_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && line_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state registers; reset abandons everything queued or in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            beat_q <= '0;
            vld_q  <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
            vld_q  <= vld_d;
        end
    end

    // Entry payload storage; contents are meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= sel_line;
            adr_q[wr_q]  <= sel_adr;
        end
    end

    // Head entry beat selection
    assign head_line = data_q[rd_q];

    always_comb begin
        BusData = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                BusData = head_line[b*AHBW +: AHBW];
            end
        end
    end

    assign BusAdr = adr_q[rd_q] + (PA_BITS'(beat_q) * PA_BITS'(STEP));

    // Line-granular collision check against every occupied entry, head included
    always_comb begin
        LookupHit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (adr_q[i][PA_BITS-1:OFF_W] == LookupAdr[PA_BITS-1:OFF_W])) begin
                LookupHit = 1'b1;
            end
        end
    end

    // Byte-offset bits of the lookup address do not take part in the compare
    assign lookup_unused = ^LookupAdr[OFF_W-1:0];

endmodule
